// File: rtl/fprint_inc_arbiter.sv
// fprint_inc_arbiter: buffers one fingerprint-completion event per physical core,
// picks pending cores round-robin and presents one event at a time to the
// overflow-tracking stage over a request/acknowledge handshake. Dropped events
// are reported through per-core sticky overrun / bad-id flags.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no request outstanding; grant the next pending core if enabled
// S_ISSUE | request held with stable ids until the overflow stage acks
module fprint_inc_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           core_fprint_done,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_task_id,
  input  logic [NUM_CORES*2-1:0]         core_logical_id,
  input  logic                           arb_enable,
  output logic                           fprint_count_inc,
  output logic [KEY_WIDTH-1:0]           fprint_task_id,
  output logic [1:0]                     fprint_logical_core_id,
  output logic [KEY_WIDTH-1:0]           fprint_physical_core_id,
  input  logic                           oflow_count_inc_ack,
  output logic [NUM_CORES-1:0]           core_pending,
  output logic [NUM_CORES-1:0]           core_overrun,
  output logic [NUM_CORES-1:0]           core_bad_id
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [NUM_CORES-1:0] overrun_q, overrun_d;
  logic [NUM_CORES-1:0] bad_id_q, bad_id_d;
  logic [KEY_WIDTH-1:0] slot_task_q [NUM_CORES];
  logic [KEY_WIDTH-1:0] slot_task_d [NUM_CORES];
  logic [1:0]           slot_lid_q  [NUM_CORES];
  logic [1:0]           slot_lid_d  [NUM_CORES];
  logic                 inc_q, inc_d;
  logic [KEY_WIDTH-1:0] out_task_q, out_task_d;
  logic [1:0]           out_lid_q, out_lid_d;
  logic [KEY_WIDTH-1:0] out_phys_q, out_phys_d;

  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_idx;

  // Round-robin search: first pending core at or above rr_ptr, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (pending_q[PTR_W'((int'(rr_ptr_q) + k) % NUM_CORES)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'((int'(rr_ptr_q) + k) % NUM_CORES);
      end
    end
    if (state_q != S_IDLE || !arb_enable) begin
      grant_valid = 1'b0;
    end
  end

  // Next-state for slots, sticky flags, pointer, handshake and presented ids.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    bad_id_d   = bad_id_q;
    slot_task_d = slot_task_q;
    slot_lid_d  = slot_lid_q;
    inc_d      = inc_q;
    out_task_d = out_task_q;
    out_lid_d  = out_lid_q;
    out_phys_d = out_phys_q;

    // A granted slot is freed first so a same-cycle event can refill it.
    if (grant_valid) begin
      pending_d[grant_idx] = 1'b0;
    end

    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_fprint_done[i]) begin
        if (core_logical_id[i*2 +: 2] == 2'd3) begin
          bad_id_d[i] = 1'b1;
        end else if (!pending_q[i] || (grant_valid && grant_idx == PTR_W'(i))) begin
          pending_d[i]   = 1'b1;
          slot_task_d[i] = core_task_id[i*KEY_WIDTH +: KEY_WIDTH];
          slot_lid_d[i]  = core_logical_id[i*2 +: 2];
        end else begin
          overrun_d[i] = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          inc_d      = 1'b1;
          out_task_d = slot_task_q[grant_idx];
          out_lid_d  = slot_lid_q[grant_idx];
          out_phys_d = KEY_WIDTH'(grant_idx);
          rr_ptr_d   = PTR_W'((int'(grant_idx) + 1) % NUM_CORES);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (oflow_count_inc_ack) begin
          inc_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        inc_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      bad_id_q   <= '0;
      inc_q      <= 1'b0;
      out_task_q <= '0;
      out_lid_q  <= '0;
      out_phys_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_task_q[i] <= '0;
        slot_lid_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      bad_id_q    <= bad_id_d;
      inc_q       <= inc_d;
      out_task_q  <= out_task_d;
      out_lid_q   <= out_lid_d;
      out_phys_q  <= out_phys_d;
      slot_task_q <= slot_task_d;
      slot_lid_q  <= slot_lid_d;
    end
  end

  assign fprint_count_inc        = inc_q;
  assign fprint_task_id          = out_task_q;
  assign fprint_logical_core_id  = out_lid_q;
  assign fprint_physical_core_id = out_phys_q;
  assign core_pending            = pending_q;
  assign core_overrun            = overrun_q;
  assign core_bad_id             = bad_id_q;

endmodule

// File: tb/tb_fprint_inc_arbiter.sv
// tb_fprint_inc_arbiter: vector table, directed corner sequences and a random
// run compared against an event-level reference model.
module tb_fprint_inc_arbiter;

  localparam int NC = 4;
  localparam int NV = 23;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  done;
  logic [15:0] tid;
  logic [7:0]  lid;
  logic        arb_enable;
  logic        ack;
  logic        inc;
  logic [3:0]  o_task;
  logic [1:0]  o_lid;
  logic [3:0]  o_phys;
  logic [3:0]  pend;
  logic [3:0]  ovr;
  logic [3:0]  bad;

  int n_vec = 0;
  int n_err = 0;

  fprint_inc_arbiter #(.NUM_CORES(NC), .KEY_WIDTH(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .core_fprint_done        (done),
    .core_task_id            (tid),
    .core_logical_id         (lid),
    .arb_enable              (arb_enable),
    .fprint_count_inc        (inc),
    .fprint_task_id          (o_task),
    .fprint_logical_core_id  (o_lid),
    .fprint_physical_core_id (o_phys),
    .oflow_count_inc_ack     (ack),
    .core_pending            (pend),
    .core_overrun            (ovr),
    .core_bad_id             (bad)
  );

  always #5 clk = ~clk;

  // Reference model: event buffer per core, a served-next pointer and one
  // outstanding request.
  logic [3:0] m_pend, m_ovr, m_bad;
  logic [3:0] m_task [NC];
  logic [1:0] m_lid  [NC];
  int         m_ptr;
  logic       m_inc;
  logic [3:0] m_otask, m_ophys;
  logic [1:0] m_olid;

  task automatic model_step(input logic r, input logic en, input logic a,
                            input logic [3:0] d, input logic [15:0] t, input logic [7:0] l);
    int g;
    g = -1;
    if (r) begin
      m_pend = '0; m_ovr = '0; m_bad = '0; m_ptr = 0; m_inc = 1'b0;
      m_otask = '0; m_olid = '0; m_ophys = '0;
      return;
    end
    if (m_inc) begin
      if (a) m_inc = 1'b0;
    end else if (en) begin
      for (int k = 0; k < NC; k++)
        if (g < 0 && m_pend[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
    end
    if (g >= 0) begin
      m_inc   = 1'b1;
      m_otask = m_task[g];
      m_olid  = m_lid[g];
      m_ophys = g[3:0];
      m_ptr   = (g + 1) % NC;
      m_pend[g] = 1'b0;
    end
    for (int i = 0; i < NC; i++) begin
      if (d[i]) begin
        if (l[i*2 +: 2] == 2'd3) m_bad[i] = 1'b1;
        else if (m_pend[i])      m_ovr[i] = 1'b1;
        else begin
          m_pend[i] = 1'b1;
          m_task[i] = t[i*4 +: 4];
          m_lid[i]  = l[i*2 +: 2];
        end
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic apply(input logic r, input logic en, input logic a,
                       input logic [3:0] d, input logic [15:0] t, input logic [7:0] l);
    reset = r; arb_enable = en; ack = a; done = d; tid = t; lid = l;
    @(posedge clk);
    model_step(r, en, a, d, t, l);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, en, a;
    logic [3:0]  d;
    logic [15:0] t;
    logic [7:0]  l;
    logic        e_inc;
    logic [3:0]  e_phys, e_task;
    logic [1:0]  e_lid;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t vt [NV];

  initial begin
    // Single event on core 2, then reset and a four-core burst, then a wrap burst.
    vt[0]  = '{1'b1,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b0,4'd0,4'd0,2'd0,4'b0000};
    vt[1]  = '{1'b0,1'b1,1'b0,4'b0100,16'h0500,8'h10, 1'b0,4'd0,4'd0,2'd0,4'b0100};
    vt[2]  = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd2,4'd5,2'd1,4'b0000};
    vt[3]  = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd2,4'd5,2'd1,4'b0000};
    vt[4]  = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd2,4'd5,2'd1,4'b0000};
    vt[5]  = '{1'b0,1'b1,1'b1,4'b0000,16'h0000,8'h00, 1'b0,4'd2,4'd5,2'd1,4'b0000};
    vt[6]  = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b0,4'd2,4'd5,2'd1,4'b0000};
    vt[7]  = '{1'b1,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b0,4'd0,4'd0,2'd0,4'b0000};
    vt[8]  = '{1'b0,1'b1,1'b0,4'b1111,16'h4321,8'h24, 1'b0,4'd0,4'd0,2'd0,4'b1111};
    vt[9]  = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd0,4'd1,2'd0,4'b1110};
    vt[10] = '{1'b0,1'b1,1'b1,4'b0000,16'h0000,8'h00, 1'b0,4'd0,4'd1,2'd0,4'b1110};
    vt[11] = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd1,4'd2,2'd1,4'b1100};
    vt[12] = '{1'b0,1'b1,1'b1,4'b0000,16'h0000,8'h00, 1'b0,4'd1,4'd2,2'd1,4'b1100};
    vt[13] = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd2,4'd3,2'd2,4'b1000};
    vt[14] = '{1'b0,1'b1,1'b1,4'b0000,16'h0000,8'h00, 1'b0,4'd2,4'd3,2'd2,4'b1000};
    vt[15] = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd3,4'd4,2'd0,4'b0000};
    vt[16] = '{1'b0,1'b1,1'b1,4'b0000,16'h0000,8'h00, 1'b0,4'd3,4'd4,2'd0,4'b0000};
    vt[17] = '{1'b0,1'b1,1'b0,4'b1001,16'h7006,8'h81, 1'b0,4'd3,4'd4,2'd0,4'b1001};
    vt[18] = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd0,4'd6,2'd1,4'b1000};
    vt[19] = '{1'b0,1'b1,1'b1,4'b0000,16'h0000,8'h00, 1'b0,4'd0,4'd6,2'd1,4'b1000};
    vt[20] = '{1'b0,1'b1,1'b0,4'b0000,16'h0000,8'h00, 1'b1,4'd3,4'd7,2'd2,4'b0000};
    vt[21] = '{1'b0,1'b1,1'b1,4'b0000,16'h0000,8'h00, 1'b0,4'd3,4'd7,2'd2,4'b0000};
    vt[22] = '{1'b0,1'b1,1'b1,4'b0000,16'h0000,8'h00, 1'b0,4'd3,4'd7,2'd2,4'b0000};

    for (int i = 0; i < NV; i++) begin
      apply(vt[i].rst, vt[i].en, vt[i].a, vt[i].d, vt[i].t, vt[i].l);
      chk($sformatf("vec%0d {inc,phys,task,lid,pend}", i),
          32'({inc, o_phys, o_task, o_lid, pend}),
          32'({vt[i].e_inc, vt[i].e_phys, vt[i].e_task, vt[i].e_lid, vt[i].e_pend}));
      if (!vt[i].rst)
        chk($sformatf("vec%0d {ovr,bad}", i), 32'({ovr, bad}), 32'd0);
    end

    // Overrun while blocked: first event retained.
    apply(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 8'h00);
    apply(1'b0, 1'b0, 1'b0, 4'b0010, 16'h0090, 8'h08);
    apply(1'b0, 1'b0, 1'b0, 4'b0010, 16'h00A0, 8'h04);
    chk("overrun flag", 32'(ovr), 32'h2);
    chk("overrun pending", 32'(pend), 32'h2);
    apply(1'b0, 1'b1, 1'b0, 4'b0000, 16'h0000, 8'h00);
    chk("overrun retained {inc,phys,task,lid}", 32'({inc, o_phys, o_task, o_lid}), 32'({1'b1, 4'd1, 4'd9, 2'd2}));
    apply(1'b0, 1'b1, 1'b1, 4'b0000, 16'h0000, 8'h00);
    chk("overrun ack inc", 32'(inc), 32'h0);

    // Reload in the same cycle as the grant.
    apply(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 8'h00);
    apply(1'b0, 1'b0, 1'b0, 4'b0010, 16'h0030, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 4'b0010, 16'h00C0, 8'h04);
    chk("reload grant {inc,phys,task,lid}", 32'({inc, o_phys, o_task, o_lid}), 32'({1'b1, 4'd1, 4'd3, 2'd0}));
    chk("reload pending", 32'(pend), 32'h2);
    chk("reload no overrun", 32'(ovr), 32'h0);
    apply(1'b0, 1'b1, 1'b1, 4'b0000, 16'h0000, 8'h00);
    chk("reload ack inc", 32'(inc), 32'h0);
    apply(1'b0, 1'b1, 1'b0, 4'b0000, 16'h0000, 8'h00);
    chk("reload second grant {inc,phys,task,lid}", 32'({inc, o_phys, o_task, o_lid}), 32'({1'b1, 4'd1, 4'd12, 2'd1}));
    apply(1'b0, 1'b1, 1'b1, 4'b0000, 16'h0000, 8'h00);

    // Illegal logical id is dropped.
    apply(1'b1, 1'b1, 1'b0, 4'b0000, 16'h0000, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 4'b0001, 16'h0005, 8'h03);
    chk("bad id flag", 32'(bad), 32'h1);
    chk("bad id pending", 32'(pend), 32'h0);
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 1'b1, 1'b0, 4'b0000, 16'h0000, 8'h00);
      chk($sformatf("bad id no request c%0d", c), 32'(inc), 32'h0);
    end

    // Long stall with enable dropped mid-request, then reset during ISSUE.
    apply(1'b1, 1'b1, 1'b0, 4'b0000, 16'h0000, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 4'b0100, 16'h0800, 8'h20);
    apply(1'b0, 1'b1, 1'b0, 4'b0000, 16'h0000, 8'h00);
    for (int c = 0; c < 50; c++) begin
      if (c == 5) apply(1'b0, 1'b1, 1'b0, 4'b1001, 16'h7000, 8'h43);
      else        apply(1'b0, (c < 20), 1'b0, 4'b0000, 16'h0000, 8'h00);
      chk($sformatf("stall c%0d {inc,phys,task,lid}", c), 32'({inc, o_phys, o_task, o_lid}),
          32'({1'b1, 4'd2, 4'd8, 2'd2}));
    end
    chk("stall pending/bad", 32'({pend, bad}), 32'({4'b1000, 4'b0001}));
    apply(1'b1, 1'b1, 1'b0, 4'b0000, 16'h0000, 8'h00);
    chk("reset mid-issue all outputs", 32'({inc, o_task, o_lid, o_phys, pend, ovr, bad}), 32'd0);
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 1'b1, 1'b0, 4'b0000, 16'h0000, 8'h00);
      chk($sformatf("post-reset no request c%0d", c), 32'(inc), 32'h0);
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic       r, en, a;
      logic [3:0] d;
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      apply(r, en, a, d, 16'($urandom), 8'($urandom));
      chk($sformatf("rand c%0d {inc,task,lid,phys,pend,ovr,bad}", c),
          32'({inc, o_task, o_lid, o_phys, pend, ovr, bad}),
          32'({m_inc, m_otask, m_olid, m_ophys, m_pend, m_ovr, m_bad}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
